fetch_unit: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the instruction decoder and controller.
- Owns the PC, issues word reads to instruction memory through a req/ack handshake, and holds the fetched word in an instruction register for decode.
- Consumes the controller's 2-bit PC-select, the register-file Rs value and the execute-complete strobe to compute and commit the next PC.

---
 rtl/cpu31_pkg.sv | 15 +
 rtl/next_pc_calc.sv | 27 ++
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu31_pkg.sv
// cpu31_pkg: shared next-PC select codes, fetch state encoding and reset PC
package cpu31_pkg;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_JR  = 2'b01;
    localparam logic [1:0] PC_SEL_BR  = 2'b10;
    localparam logic [1:0] PC_SEL_J   = 2'b11;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC mux for seq, jr, branch-taken and j/jal
module next_pc_calc
    import cpu31_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] instr,
    input  logic [31:0] rs_data,
    input  logic [1:0]  pc_sel,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic [31:0] pc4;
    logic [31:0] br_off;

    // Branch offset is the sign-extended word displacement; jump keeps pc+4's top nibble
    always_comb begin
        pc4      = pc + 32'd4;
        br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};
        next_pc  = (pc_sel == PC_SEL_SEQ) ? pc4 :
                   (pc_sel == PC_SEL_JR)  ? rs_data :
                   (pc_sel == PC_SEL_BR)  ? pc4 + br_off :
                                            {pc4[31:28], instr, 2'b00};
        misalign = (pc_sel == PC_SEL_JR) && (rs_data[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, imem req/ack fetch and instruction register; FETCH_TIMEOUT_EN adds a fetch watchdog
module fetch_unit
    import cpu31_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT_CYCLES = 16
)
(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] rs_data,
    input  logic        exec_done,
    input  logic        halt_req,
    output logic        halted,
    output logic        addr_err,
    output logic        fetch_err
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        addr_err_q, addr_err_d;
    logic [31:0] next_pc;
    logic        misalign;
`ifdef FETCH_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        fetch_err_q, fetch_err_d;
`endif

    next_pc_calc u_next_pc (
        .pc       (pc_q),
        .instr    (instr_q[25:0]),
        .rs_data  (rs_data),
        .pc_sel   (pc_sel),
        .next_pc  (next_pc),
        .misalign (misalign)
    );

    // Fetch/execute/halt sequencing and PC commit
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        addr_err_d = addr_err_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d       = cnt_q;
        fetch_err_d = fetch_err_q;
`endif
        if (state_q == S_FETCH) begin
            if (imem_ack) begin
                instr_d = imem_rdata;
                state_d = S_EXEC;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (cnt_q + 32'd1 == TIMEOUT_CYCLES) begin
                fetch_err_d = 1'b1;
                state_d     = S_HALT;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
`endif
        end else if (state_q == S_EXEC && exec_done) begin
            pc_d       = next_pc;
            addr_err_d = addr_err_q | misalign;
            state_d    = (halt_req || misalign) ? S_HALT : S_FETCH;
`ifdef FETCH_TIMEOUT_EN
            cnt_d = '0;
`endif
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            addr_err_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q       <= '0;
            fetch_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            addr_err_q <= addr_err_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q       <= cnt_d;
            fetch_err_q <= fetch_err_d;
`endif
        end
    end

    assign imem_req    = (state_q == S_FETCH);
    assign instr_valid = (state_q == S_EXEC);
    assign halted      = (state_q == S_HALT);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr       = instr_q;
    assign addr_err    = addr_err_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, directed corner sequences and randomized model check of fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;
    localparam int          TO  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [31:0] instr, pc, pc_plus4, rs_data = '0;
    logic        instr_valid, halted, addr_err, fetch_err;
    logic [1:0]  pc_sel = 2'b00;
    logic        exec_done = 1'b0, halt_req = 1'b0;

    int n_tot = 0;
    int n_pass = 0;

    fetch_unit #(.RESET_PC(RPC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .pc_sel(pc_sel), .rs_data(rs_data), .exec_done(exec_done), .halt_req(halt_req),
        .halted(halted), .addr_err(addr_err), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [1:0]  sel;
        logic [31:0] rs;
        logic        hreq;
        logic [31:0] exp_pc;
        logic        exp_halted;
        logic        exp_aerr;
    } vec_t;

    typedef enum {M_FETCH, M_EXEC, M_STOP} mode_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] w);
        imem_ack = 1'b1;
        imem_rdata = w;
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic exec(input logic [1:0] sel, input logic [31:0] rs, input logic h);
        exec_done = 1'b1;
        pc_sel = sel;
        rs_data = rs;
        halt_req = h;
        tick();
        exec_done = 1'b0;
        halt_req = 1'b0;
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                             input logic [1:0] sel, input logic [31:0] rs);
        int off;
        off = int'($signed(ins[15:0]));
        case (sel)
            2'd0: return p + 32'd4;
            2'd1: return rs;
            2'd2: return p + 32'd4 + 32'(off * 4);
            default: return ((p + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        endcase
    endfunction

    vec_t vecs[9];

    mode_t       m_mode;
    logic [31:0] m_pc, m_ins;
    logic        m_aerr, m_ferr;
    int          m_wait;

    initial begin
        vecs[0] = '{32'h0000_0000, 2'b00, 32'h0,         1'b0, 32'h0040_0004, 1'b0, 1'b0};
        vecs[1] = '{32'h1000_FFFF, 2'b10, 32'h0,         1'b0, 32'h0040_0000, 1'b0, 1'b0};
        vecs[2] = '{32'h1000_0003, 2'b10, 32'h0,         1'b0, 32'h0040_0010, 1'b0, 1'b0};
        vecs[3] = '{32'h1000_8000, 2'b10, 32'h0,         1'b0, 32'h003E_0004, 1'b0, 1'b0};
        vecs[4] = '{32'h0BFF_FFFF, 2'b11, 32'h0,         1'b0, 32'h0FFF_FFFC, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0000, 2'b01, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_0000, 2'b01, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b1, 1'b1};
        vecs[7] = '{32'h0000_0000, 2'b01, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0};
        vecs[8] = '{32'h0000_0000, 2'b00, 32'h0,         1'b1, 32'h0040_0004, 1'b1, 1'b0};

        @(negedge clk);
        do_reset();
        chk("rst_pc", pc, RPC);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_req", 32'(imem_req), 32'd1);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_flags", {29'd0, halted, addr_err, fetch_err}, 32'd0);

        fetch(32'h2008_0005);
        chk("zw_valid", 32'(instr_valid), 32'd1);
        chk("zw_instr", instr, 32'h2008_0005);
        chk("zw_req", 32'(imem_req), 32'd0);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("exec_ack_ignored", instr, 32'h2008_0005);
        exec(2'b00, 32'h0, 1'b0);
        chk("seq_pc", pc, 32'h0040_0004);
        chk("seq_refetch", 32'(imem_req), 32'd1);

        for (int i = 0; i < 3; i++) begin
            fetch(32'h0);
            exec(2'b00, 32'h0, 1'b0);
        end
        chk("pc_0x10", pc, 32'h0040_0010);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk("fetch_done_ignored", pc, 32'h0040_0010);
        fetch(32'h1000_FFFE);
        exec(2'b10, 32'h0, 1'b0);
        chk("br_back", pc, 32'h0040_000C);
        fetch(32'h0810_0008);
        exec(2'b11, 32'h0, 1'b0);
        chk("j_pc", pc, 32'h0040_0020);
        fetch(32'h0C10_0008);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("halt_no_done", 32'(halted), 32'd0);
        chk("exec_pc4", pc_plus4, 32'h0040_0024);
        exec(2'b11, 32'h0, 1'b0);
        chk("jal_pc", pc, 32'h0040_0020);
        fetch(32'h0);
        exec(2'b01, 32'h0040_0102, 1'b0);
        chk("mis_pc", pc, 32'h0040_0102);
        chk("mis_aerr", 32'(addr_err), 32'd1);
        chk("mis_halted", 32'(halted), 32'd1);
        imem_ack = 1'b1;
        imem_rdata = 32'h1111_1111;
        tick();
        tick();
        imem_ack = 1'b0;
        chk("halt_req0", 32'(imem_req), 32'd0);
        chk("halt_valid0", 32'(instr_valid), 32'd0);
        chk("halt_instr", instr, 32'h0);

        do_reset();
        fetch(32'h0);
        exec(2'b01, 32'hFFFF_FFFC, 1'b0);
        chk("wrap_pc4", pc_plus4, 32'h0);
        fetch(32'h0800_0010);
        exec(2'b11, 32'h0, 1'b0);
        chk("wrap_j", pc, 32'h0000_0040);
        do_reset();
        fetch(32'h0);
        exec(2'b01, 32'hFFFF_FFFC, 1'b0);
        fetch(32'h0);
        exec(2'b00, 32'h0, 1'b0);
        chk("wrap_seq", pc, 32'h0);

        do_reset();
        tick();
        rst = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        tick();
        rst = 1'b0;
        imem_ack = 1'b0;
        chk("midrst_pc", pc, RPC);
        chk("midrst_instr", instr, 32'h0);
        chk("midrst_req", 32'(imem_req), 32'd1);
        tick();
        chk("midrst_valid", 32'(instr_valid), 32'd0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            fetch(vecs[i].ins);
            exec(vecs[i].sel, vecs[i].rs, vecs[i].hreq);
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].exp_halted));
            chk($sformatf("vec%0d_aerr", i), 32'(addr_err), 32'(vecs[i].exp_aerr));
        end

`ifdef FETCH_TIMEOUT_EN
        do_reset();
        for (int i = 0; i < TO - 1; i++) tick();
        chk("to_not_yet", 32'(halted), 32'd0);
        tick();
        chk("to_ferr", 32'(fetch_err), 32'd1);
        chk("to_halted", 32'(halted), 32'd1);
        do_reset();
        for (int i = 0; i < TO - 1; i++) tick();
        fetch(32'h1234_0000);
        chk("to_ack_wins", 32'(fetch_err), 32'd0);
        chk("to_ack_instr", instr, 32'h1234_0000);
`endif

        do_reset();
        m_mode = M_FETCH; m_pc = RPC; m_ins = '0; m_aerr = 1'b0; m_ferr = 1'b0; m_wait = 0;
        for (int c = 0; c < 400; c++) begin
            chk("rnd_pc", pc, m_pc);
            chk("rnd_instr", instr, m_ins);
            chk("rnd_ctl", {27'd0, imem_req, instr_valid, halted, addr_err, fetch_err},
                {27'd0, m_mode == M_FETCH, m_mode == M_EXEC, m_mode == M_STOP, m_aerr, m_ferr});
            rst        = (m_mode == M_STOP) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
            imem_ack   = $urandom_range(0, 2) == 0;
            imem_rdata = $urandom;
            exec_done  = $urandom_range(0, 1) == 1;
            pc_sel     = 2'($urandom_range(0, 3));
            rs_data    = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            halt_req   = $urandom_range(0, 9) == 0;
            if (rst) begin
                m_mode = M_FETCH; m_pc = RPC; m_ins = '0; m_aerr = 1'b0; m_ferr = 1'b0; m_wait = 0;
            end else if (m_mode == M_FETCH) begin
                if (imem_ack) begin
                    m_ins = imem_rdata;
                    m_mode = M_EXEC;
                end
`ifdef FETCH_TIMEOUT_EN
                else begin
                    m_wait++;
                    if (m_wait == TO) begin
                        m_ferr = 1'b1;
                        m_mode = M_STOP;
                    end
                end
`endif
            end else if (m_mode == M_EXEC && exec_done) begin
                m_pc = ref_next(m_pc, m_ins, pc_sel, rs_data);
                m_wait = 0;
                if (pc_sel == 2'd1 && rs_data[1:0] != 2'd0) begin
                    m_aerr = 1'b1;
                    m_mode = M_STOP;
                end else begin
                    m_mode = halt_req ? M_STOP : M_FETCH;
                end
            end
            tick();
        end
        rst = 1'b0;
        imem_ack = 1'b0;
        exec_done = 1'b0;
        halt_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
